// File: rtl/mt_stream_packet_tx.sv
// Store-and-forward stream transmitter: words are buffered per packet and only
// released to the stream side once the packet's last word has been committed.
module mt_stream_packet_tx #(
  parameter int g_data_width = 32,
  parameter int g_addr_width = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [g_data_width-1:0] wr_data_i,
  input  logic                    wr_last_i,
  input  logic                    wr_abort_i,
  output logic                    src_valid_o,
  output logic [g_data_width-1:0] src_data_o,
  output logic                    src_last_o,
  input  logic                    src_ready_i,
  output logic [g_addr_width:0]   pkt_count_o,
  output logic                    full_o,
  output logic                    drop_o,
  output logic                    busy_o
);

  localparam int depth = 2 ** g_addr_width;
  localparam logic [g_addr_width:0] depth_c = {1'b1, {g_addr_width{1'b0}}};
  localparam logic [g_addr_width:0] one_c   = {{g_addr_width{1'b0}}, 1'b1};

  localparam logic [0:0] st_idle = 1'b0;
  localparam logic [0:0] st_send = 1'b1;

  logic [g_data_width:0] mem [depth];
  logic [g_addr_width:0] wr_ptr;
  logic [g_addr_width:0] commit_ptr;
  logic [g_addr_width:0] rd_ptr;
  logic [g_addr_width:0] used;
  logic [g_addr_width:0] pkt_count;
  logic [g_data_width:0] rd_word;
  logic [0:0]            state;
  logic                  ovf;
  logic                  full;
  logic                  wr_store;
  logic                  wr_commit;
  logic                  handshake;
  logic                  pop_last;

  // Pointers carry one extra bit so that a full buffer is distinguishable from an empty one.
  assign used      = wr_ptr - rd_ptr;
  assign full      = (used == depth_c);
  assign rd_word   = mem[rd_ptr[g_addr_width-1:0]];
  assign wr_store  = wr_en_i && !wr_abort_i && !full && !ovf;
  assign wr_commit = wr_store && wr_last_i;
  assign handshake = src_valid_o && src_ready_i;
  assign pop_last  = (state == st_send) && handshake && src_last_o;

  always_ff @(posedge clk_i) begin
    if (wr_store) begin
      mem[wr_ptr[g_addr_width-1:0]] <= {wr_last_i, wr_data_i};
    end
  end

  // An overflowing packet is swallowed word by word until its last word rewinds the write pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      ovf        <= 1'b0;
      drop_o     <= 1'b0;
    end else begin
      drop_o <= 1'b0;
      if (wr_abort_i) begin
        wr_ptr <= commit_ptr;
        ovf    <= 1'b0;
      end else if (wr_en_i) begin
        if (ovf || full) begin
          if (wr_last_i) begin
            wr_ptr <= commit_ptr;
            ovf    <= 1'b0;
            drop_o <= 1'b1;
          end else begin
            ovf <= 1'b1;
          end
        end else begin
          wr_ptr <= wr_ptr + one_c;
          if (wr_last_i) begin
            commit_ptr <= wr_ptr + one_c;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pkt_count <= '0;
    end else if (wr_commit && !pop_last) begin
      pkt_count <= pkt_count + one_c;
    end else if (pop_last && !wr_commit) begin
      pkt_count <= pkt_count - one_c;
    end
  end

  // The output registers are refilled straight from the buffer so consecutive words need no bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= st_idle;
      rd_ptr      <= '0;
      src_valid_o <= 1'b0;
      src_data_o  <= '0;
      src_last_o  <= 1'b0;
    end else begin
      case (state)
        st_idle: begin
          if (pkt_count != '0) begin
            src_valid_o              <= 1'b1;
            {src_last_o, src_data_o} <= rd_word;
            rd_ptr                   <= rd_ptr + one_c;
            state                    <= st_send;
          end
        end
        st_send: begin
          if (handshake) begin
            if (src_last_o) begin
              src_valid_o <= 1'b0;
              state       <= st_idle;
            end else begin
              {src_last_o, src_data_o} <= rd_word;
              rd_ptr                   <= rd_ptr + one_c;
            end
          end
        end
        default: state <= st_idle;
      endcase
    end
  end

  assign pkt_count_o = pkt_count;
  assign full_o      = full;
  assign busy_o      = (state == st_send);

endmodule

// File: tb/tb_mt_stream_packet_tx.sv
// Self-checking bench for mt_stream_packet_tx: cycle tables, directed corner
// cases and a randomized packet stream scored against a packet-queue model.
module tb_mt_stream_packet_tx;

  localparam int dw = 32;
  localparam int aw = 5;
  localparam int depth = 32;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [dw-1:0] wr_data;
  logic          wr_last;
  logic          wr_abort;
  logic          src_valid;
  logic [dw-1:0] src_data;
  logic          src_last;
  logic          src_ready;
  logic [aw:0]   pkt_count;
  logic          full;
  logic          drop;
  logic          busy;

  int n_compared;
  int n_mismatched;
  int drop_seen;
  bit rand_ready;

  logic [dw:0] recv[$];
  logic [dw:0] exp_q[$];

  typedef struct {
    logic          wr_en;
    logic [dw-1:0] wr_data;
    logic          wr_last;
    logic          ready;
    logic          exp_valid;
    logic [dw-1:0] exp_data;
    logic          exp_last;
    logic [aw:0]   exp_count;
    logic          exp_busy;
  } vec_t;

  vec_t t1[10];
  vec_t t3[11];

  mt_stream_packet_tx #(.g_data_width(dw), .g_addr_width(aw)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .wr_en_i(wr_en),
    .wr_data_i(wr_data),
    .wr_last_i(wr_last),
    .wr_abort_i(wr_abort),
    .src_valid_o(src_valid),
    .src_data_o(src_data),
    .src_last_o(src_last),
    .src_ready_i(src_ready),
    .pkt_count_o(pkt_count),
    .full_o(full),
    .drop_o(drop),
    .busy_o(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeWord(input logic [dw-1:0] d, input logic l);
    wr_en   = 1'b1;
    wr_data = d;
    wr_last = l;
    tick();
    wr_en   = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic applyStimulus(input string tag, input vec_t v);
    wr_en     = v.wr_en;
    wr_data   = v.wr_data;
    wr_last   = v.wr_last;
    src_ready = v.ready;
    tick();
    checkOutput({tag, " valid"}, src_valid, v.exp_valid);
    checkOutput({tag, " count"}, pkt_count, v.exp_count);
    checkOutput({tag, " busy"}, busy, v.exp_busy);
    if (v.exp_valid) begin
      checkOutput({tag, " data"}, src_data, v.exp_data);
      checkOutput({tag, " last"}, src_last, v.exp_last);
    end
  endtask

  task automatic waitRecv(input int n, input int budget);
    int c;
    c = 0;
    while (recv.size() < n && c < budget) begin
      tick();
      c++;
    end
    repeat (4) tick();
  endtask

  task automatic checkRecv(input string name);
    checkOutput({name, " length"}, recv.size(), exp_q.size());
    for (int i = 0; i < recv.size() && i < exp_q.size(); i++) begin
      checkOutput($sformatf("%s word%0d", name, i), recv[i], exp_q[i]);
    end
  endtask

  function automatic vec_t mk(logic en, logic [dw-1:0] d, logic l, logic r, logic ev,
                              logic [dw-1:0] ed, logic el, logic [aw:0] ec, logic eb);
    vec_t v;
    v.wr_en = en; v.wr_data = d; v.wr_last = l; v.ready = r;
    v.exp_valid = ev; v.exp_data = ed; v.exp_last = el; v.exp_count = ec; v.exp_busy = eb;
    return v;
  endfunction

  // Stream sink: records every handshake and requires stalled words to hold still.
  initial begin
    logic        stalled;
    logic [dw:0] held;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          checkOutput("stall valid", src_valid, 1'b1);
          checkOutput("stall word", {src_last, src_data}, held);
        end
        if (src_valid && src_ready) recv.push_back({src_last, src_data});
        stalled = src_valid && !src_ready;
        held    = {src_last, src_data};
        if (drop) drop_seen++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) src_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int base_drop;
    int c;
    n_compared = 0; n_mismatched = 0; drop_seen = 0; rand_ready = 0;
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; wr_last = 1'b0; wr_abort = 1'b0; src_ready = 1'b0;

    t1[0] = mk(1, 32'h11, 0, 1, 0, 0, 0, 0, 0);
    t1[1] = mk(1, 32'h22, 0, 1, 0, 0, 0, 0, 0);
    t1[2] = mk(1, 32'h33, 0, 1, 0, 0, 0, 0, 0);
    t1[3] = mk(1, 32'h44, 1, 1, 0, 0, 0, 1, 0);
    t1[4] = mk(0, 0, 0, 1, 1, 32'h11, 0, 1, 1);
    t1[5] = mk(0, 0, 0, 1, 1, 32'h22, 0, 1, 1);
    t1[6] = mk(0, 0, 0, 1, 1, 32'h33, 0, 1, 1);
    t1[7] = mk(0, 0, 0, 1, 1, 32'h44, 1, 1, 1);
    t1[8] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0);
    t1[9] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0);

    t3[0]  = mk(1, 32'hA0, 0, 0, 0, 0, 0, 0, 0);
    t3[1]  = mk(1, 32'hA1, 0, 0, 0, 0, 0, 0, 0);
    t3[2]  = mk(1, 32'hA2, 1, 0, 0, 0, 0, 1, 0);
    t3[3]  = mk(1, 32'hB0, 0, 0, 1, 32'hA0, 0, 1, 1);
    t3[4]  = mk(1, 32'hB1, 1, 0, 1, 32'hA0, 0, 2, 1);
    t3[5]  = mk(0, 0, 0, 1, 1, 32'hA1, 0, 2, 1);
    t3[6]  = mk(0, 0, 0, 1, 1, 32'hA2, 1, 2, 1);
    t3[7]  = mk(0, 0, 0, 1, 0, 0, 0, 1, 0);
    t3[8]  = mk(0, 0, 0, 1, 1, 32'hB0, 0, 1, 1);
    t3[9]  = mk(0, 0, 0, 1, 1, 32'hB1, 1, 1, 1);
    t3[10] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0);

    repeat (2) tick();
    checkOutput("reset valid", src_valid, 0);
    checkOutput("reset last", src_last, 0);
    checkOutput("reset data", src_data, 0);
    checkOutput("reset count", pkt_count, 0);
    checkOutput("reset full", full, 0);
    checkOutput("reset drop", drop, 0);
    checkOutput("reset busy", busy, 0);
    rst = 1'b0;
    tick();

    $display("[TB] basic four-word packet");
    for (int i = 0; i < 10; i++) applyStimulus($sformatf("t1[%0d]", i), t1[i]);
    wr_en = 1'b0;

    $display("[TB] random backpressure");
    recv.delete(); exp_q.delete();
    exp_q.push_back({1'b0, 32'h11}); exp_q.push_back({1'b0, 32'h22});
    exp_q.push_back({1'b0, 32'h33}); exp_q.push_back({1'b1, 32'h44});
    rand_ready = 1;
    writeWord(32'h11, 0); writeWord(32'h22, 0); writeWord(32'h33, 0); writeWord(32'h44, 1);
    waitRecv(4, 200);
    rand_ready = 0;
    checkRecv("stall pkt");
    checkOutput("stall pkt count", pkt_count, 0);

    $display("[TB] two queued packets");
    src_ready = 1'b0;
    tick();
    for (int i = 0; i < 11; i++) applyStimulus($sformatf("t3[%0d]", i), t3[i]);
    wr_en = 1'b0;

    $display("[TB] overflow drop");
    src_ready = 1'b0;
    base_drop = drop_seen;
    for (int i = 0; i < 40; i++) begin
      writeWord(32'h100 + i, i == 39);
      if (i == 30) checkOutput("ovf full below depth", full, 0);
      if (i == 31) checkOutput("ovf full at depth", full, 1);
      if (i == 35) checkOutput("ovf full held", full, 1);
      if (i == 38) checkOutput("ovf no early drop", drop, 0);
      if (i == 39) begin
        checkOutput("ovf drop pulse", drop, 1);
        checkOutput("ovf full cleared", full, 0);
        checkOutput("ovf count", pkt_count, 0);
        checkOutput("ovf valid", src_valid, 0);
      end
    end
    tick();
    checkOutput("ovf drop ends", drop, 0);
    checkOutput("ovf single pulse", drop_seen - base_drop, 1);
    recv.delete(); exp_q.delete();
    src_ready = 1'b1;
    exp_q.push_back({1'b0, 32'hC0}); exp_q.push_back({1'b1, 32'hC1});
    writeWord(32'hC0, 0); writeWord(32'hC1, 1);
    waitRecv(2, 50);
    checkRecv("post ovf");

    $display("[TB] abort");
    recv.delete(); exp_q.delete();
    base_drop = drop_seen;
    writeWord(32'hE1, 0); writeWord(32'hE2, 0); writeWord(32'hE3, 0);
    wr_abort = 1'b1; wr_en = 1'b1; wr_last = 1'b1; wr_data = 32'hEE;
    tick();
    wr_abort = 1'b0; wr_en = 1'b0; wr_last = 1'b0;
    repeat (6) tick();
    checkOutput("abort nothing sent", recv.size(), 0);
    checkOutput("abort count", pkt_count, 0);
    checkOutput("abort no drop", drop_seen - base_drop, 0);
    exp_q.push_back({1'b1, 32'hD0});
    writeWord(32'hD0, 1);
    waitRecv(1, 50);
    checkRecv("post abort");

    $display("[TB] reset mid-packet");
    recv.delete(); exp_q.delete();
    for (int i = 0; i < 5; i++) writeWord(32'hF0 + i, i == 4);
    c = 0;
    while (recv.size() < 2 && c < 50) begin
      tick();
      c++;
    end
    checkOutput("midrst two sent", recv.size(), 2);
    checkOutput("midrst busy before", busy, 1);
    rst = 1'b1; src_ready = 1'b0;
    tick();
    rst = 1'b0;
    checkOutput("midrst valid", src_valid, 0);
    checkOutput("midrst count", pkt_count, 0);
    checkOutput("midrst busy", busy, 0);
    tick();
    recv.delete(); exp_q.delete();
    src_ready = 1'b1;
    exp_q.push_back({1'b0, 32'h60}); exp_q.push_back({1'b1, 32'h61});
    writeWord(32'h60, 0); writeWord(32'h61, 1);
    waitRecv(2, 50);
    checkRecv("post midrst");

    // Packets only start when the model's undelivered words leave room, so none may be dropped.
    $display("[TB] random packet stream");
    recv.delete(); exp_q.delete();
    base_drop = drop_seen;
    rand_ready = 1;
    for (int p = 0; p < 40; p++) begin
      int len;
      bit do_abort;
      logic [dw:0] pending[$];
      len = $urandom_range(1, 8);
      do_abort = ($urandom_range(0, 7) == 0);
      c = 0;
      while ((exp_q.size() - recv.size() + len > depth) && c < 500) begin
        tick();
        c++;
      end
      pending.delete();
      for (int w = 0; w < len; w++) begin
        logic [dw-1:0] d;
        logic l;
        d = $urandom;
        l = !do_abort && (w == len - 1);
        if ($urandom_range(0, 3) == 0) tick();
        pending.push_back({l, d});
        writeWord(d, l);
      end
      if (do_abort) begin
        wr_abort = 1'b1; wr_en = 1'($urandom_range(0, 1)); wr_last = 1'b1; wr_data = $urandom;
        tick();
        wr_abort = 1'b0; wr_en = 1'b0; wr_last = 1'b0;
      end else begin
        foreach (pending[k]) exp_q.push_back(pending[k]);
      end
    end
    waitRecv(exp_q.size(), 3000);
    rand_ready = 0;
    src_ready = 1'b1;
    checkRecv("random");
    checkOutput("random count", pkt_count, 0);
    checkOutput("random busy", busy, 0);
    checkOutput("random no drops", drop_seen - base_drop, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
